// File: rtl/fetch_pkg.sv
// Shared widths and FSM state encoding for the instruction fetch stage.
package fetch_pkg;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_WIDTH    = 32;

   typedef enum logic [1:0] {
      FETCH_RUN  = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_icache_array.sv
// Direct-mapped instruction cache storage: combinational tag compare and word read,
// one fill write port. Only the valid bits are reset.
module icache_array
   import fetch_pkg::*;
#(
   parameter  int LINES      = 4,
   parameter  int LINE_BYTES = 16,
   localparam int OFF_W      = $clog2(LINE_BYTES),
   localparam int IDX_W      = $clog2(LINES),
   localparam int TAG_W      = PC_WIDTH - IDX_W - OFF_W,
   localparam int WORDS      = LINE_BYTES / 4,
   localparam int LINE_W     = LINE_BYTES * 8
) (
   input  logic                   clock,
   input  logic                   reset_c,
   input  logic [IDX_W-1:0]       rd_idx,
   input  logic [TAG_W-1:0]       rd_tag,
   input  logic [OFF_W-1:0]       rd_word,
   output logic                   rd_hit,
   output logic [INSTR_WIDTH-1:0] rd_instr,
   input  logic                   wr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [TAG_W-1:0]       wr_tag,
   input  logic [LINE_W-1:0]      wr_line
);

   logic [LINES-1:0]  valid_q;
   logic [LINES-1:0]  valid_d;
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [LINE_W-1:0] data_q [LINES];

   always_comb begin
      valid_d = valid_q;
      if (wr_en) valid_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_c) begin
      if (!reset_c) valid_q <= '0;
      else          valid_q <= valid_d;
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_line;
      end
   end

   assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

   always_comb begin
      rd_instr = '0;
      for (int w = 0; w < WORDS; w++) begin
         if (rd_word == OFF_W'(w)) rd_instr = data_q[rd_idx][w*INSTR_WIDTH +: INSTR_WIDTH];
      end
   end

endmodule

// File: rtl/fetch_top.sv
// Instruction fetch stage: PC, icache lookup, line fill over req/rsp, redirect handling.
//   state      | meaning
//   FETCH_RUN  | look up pc each cycle; hit -> emit instr, miss -> start fill
//   FETCH_REQ  | fill request presented, waiting for mem_req_ready
//   FETCH_WAIT | request accepted, waiting for mem_rsp_valid to install the line
module fetch_top
   import fetch_pkg::*;
#(
   parameter logic [31:0] BOOT_PC      = 32'h0000_1000,
   parameter int          ICACHE_LINES = 4,
   parameter int          LINE_BYTES   = 16
) (
   input  logic                    clock,
   input  logic                    reset_c,
   input  logic                    stall_fetch,
   input  logic                    branch_taken,
   input  logic [PC_WIDTH-1:0]     branch_pc,
   output logic                    fetch_instr_valid,
   output logic [INSTR_WIDTH-1:0]  fetch_instr_data,
   output logic [PC_WIDTH-1:0]     fetch_pc,
   output logic                    fetch_exc_valid,
   output logic                    mem_req_valid,
   output logic [PC_WIDTH-1:0]     mem_req_addr,
   input  logic                    mem_req_ready,
   input  logic                    mem_rsp_valid,
   input  logic [LINE_BYTES*8-1:0] mem_rsp_data
);

   localparam int OFF_W = $clog2(LINE_BYTES);
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = PC_WIDTH - IDX_W - OFF_W;

   fetch_state_t           state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    pend_pc_q, pend_pc_d;
   logic                   pend_vld_q, pend_vld_d;
   logic                   exc_q, exc_d;
   logic                   instr_valid_q, instr_valid_d;
   logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
   logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
   logic                   req_valid_q, req_valid_d;
   logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;

   logic                   hit;
   logic [INSTR_WIDTH-1:0] hit_instr;
   logic                   fill_en;
   logic [OFF_W-1:0]       pc_off;
   logic [OFF_W-1:0]       pc_word;

   assign pc_off  = pc_q[OFF_W-1:0];
   assign pc_word = pc_off >> 2;

   icache_array #(
      .LINES      (ICACHE_LINES),
      .LINE_BYTES (LINE_BYTES)
   ) u_icache (
      .clock    (clock),
      .reset_c  (reset_c),
      .rd_idx   (pc_q[OFF_W +: IDX_W]),
      .rd_tag   (pc_q[PC_WIDTH-1 -: TAG_W]),
      .rd_word  (pc_word),
      .rd_hit   (hit),
      .rd_instr (hit_instr),
      .wr_en    (fill_en),
      .wr_idx   (req_addr_q[OFF_W +: IDX_W]),
      .wr_tag   (req_addr_q[PC_WIDTH-1 -: TAG_W]),
      .wr_line  (mem_rsp_data)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_pc_d     = pend_pc_q;
      pend_vld_d    = pend_vld_q;
      exc_d         = exc_q;
      instr_valid_d = instr_valid_q;
      instr_data_d  = instr_data_q;
      fetch_pc_d    = fetch_pc_q;
      req_valid_d   = req_valid_q;
      req_addr_d    = req_addr_q;
      fill_en       = 1'b0;

      case (state_q)
         FETCH_RUN: begin
            if (branch_taken) begin
               pc_d          = branch_pc;
               instr_valid_d = 1'b0;
               exc_d         = |branch_pc[1:0];
            end else if (exc_q || stall_fetch) begin
               // frozen on a misaligned pc, or decode back-pressure: hold everything
            end else if (hit) begin
               instr_data_d  = hit_instr;
               fetch_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + PC_WIDTH'(4);
            end else begin
               instr_valid_d = 1'b0;
               req_addr_d    = {pc_q[PC_WIDTH-1:OFF_W], OFF_W'(0)};
               req_valid_d   = 1'b1;
               state_d       = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (branch_taken) begin
               pend_pc_d  = branch_pc;
               pend_vld_d = 1'b1;
            end
            if (mem_req_ready) begin
               req_valid_d = 1'b0;
               state_d     = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (branch_taken) begin
               pend_pc_d  = branch_pc;
               pend_vld_d = 1'b1;
            end
            if (mem_rsp_valid) begin
               fill_en = 1'b1;
               state_d = FETCH_RUN;
               // a redirect seen during the fill takes effect as the fill completes
               if (pend_vld_d) begin
                  pc_d  = pend_pc_d;
                  exc_d = |pend_pc_d[1:0];
               end
               pend_vld_d = 1'b0;
            end
         end
         default: state_d = FETCH_RUN;
      endcase
   end

   always_ff @(posedge clock or negedge reset_c) begin
      if (!reset_c) begin
         state_q       <= FETCH_RUN;
         pc_q          <= BOOT_PC;
         pend_pc_q     <= '0;
         pend_vld_q    <= 1'b0;
         exc_q         <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_data_q  <= '0;
         fetch_pc_q    <= BOOT_PC;
         req_valid_q   <= 1'b0;
         req_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_pc_q     <= pend_pc_d;
         pend_vld_q    <= pend_vld_d;
         exc_q         <= exc_d;
         instr_valid_q <= instr_valid_d;
         instr_data_q  <= instr_data_d;
         fetch_pc_q    <= fetch_pc_d;
         req_valid_q   <= req_valid_d;
         req_addr_q    <= req_addr_d;
      end
   end

   assign fetch_instr_valid = instr_valid_q;
   assign fetch_instr_data  = instr_data_q;
   assign fetch_pc          = fetch_pc_q;
   assign fetch_exc_valid   = exc_q;
   assign mem_req_valid     = req_valid_q;
   assign mem_req_addr      = req_addr_q;

endmodule

// File: tb/tb_fetch_top.sv
// Directed bench for fetch_top: cold miss, stall, redirect during fill, slow ready,
// misaligned branch exception, reset during fill.
module tb_fetch_top;

   logic         clock = 1'b0;
   logic         reset_c;
   logic         stall_fetch;
   logic         branch_taken;
   logic [31:0]  branch_pc;
   logic         fetch_instr_valid;
   logic [31:0]  fetch_instr_data;
   logic [31:0]  fetch_pc;
   logic         fetch_exc_valid;
   logic         mem_req_valid;
   logic [31:0]  mem_req_addr;
   logic         mem_req_ready;
   logic         mem_rsp_valid;
   logic [127:0] mem_rsp_data;

   int n_cmp = 0;
   int n_bad = 0;

   fetch_top dut (
      .clock             (clock),
      .reset_c           (reset_c),
      .stall_fetch       (stall_fetch),
      .branch_taken      (branch_taken),
      .branch_pc         (branch_pc),
      .fetch_instr_valid (fetch_instr_valid),
      .fetch_instr_data  (fetch_instr_data),
      .fetch_pc          (fetch_pc),
      .fetch_exc_valid   (fetch_exc_valid),
      .mem_req_valid     (mem_req_valid),
      .mem_req_addr      (mem_req_addr),
      .mem_req_ready     (mem_req_ready),
      .mem_rsp_valid     (mem_rsp_valid),
      .mem_rsp_data      (mem_rsp_data)
   );

   always #5 clock = ~clock;

   // instruction memory contents: word at byte address a
   function automatic logic [31:0] word_at(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   function automatic logic [127:0] line_at(input logic [31:0] a);
      return {word_at(a + 32'd12), word_at(a + 32'd8), word_at(a + 32'd4), word_at(a)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic chk_out(input string tag, input logic [31:0] a);
      chk({tag, " valid"}, 32'(fetch_instr_valid), 32'd1);
      chk({tag, " data"},  fetch_instr_data, word_at(a));
      chk({tag, " pc"},    fetch_pc, a);
   endtask

   initial begin
      reset_c       = 1'b0;
      stall_fetch   = 1'b0;
      branch_taken  = 1'b0;
      branch_pc     = '0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      @(negedge clock);
      chk("rst valid",    32'(fetch_instr_valid), 32'd0);
      chk("rst data",     fetch_instr_data, 32'd0);
      chk("rst pc",       fetch_pc, 32'h1000);
      chk("rst exc",      32'(fetch_exc_valid), 32'd0);
      chk("rst req",      32'(mem_req_valid), 32'd0);
      chk("rst req addr", mem_req_addr, 32'd0);
      tick();
      reset_c = 1'b1;

      // cold start miss at boot pc
      tick();
      chk("cold req",      32'(mem_req_valid), 32'd1);
      chk("cold req addr", mem_req_addr, 32'h1000);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      chk("cold req drop", 32'(mem_req_valid), 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_at(32'h1000);
      tick();
      mem_rsp_valid = 1'b0;
      chk("fill no valid", 32'(fetch_instr_valid), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_out("seq", 32'h1000 + 32'(4 * i));
      end
      tick();
      chk("next miss valid", 32'(fetch_instr_valid), 32'd0);
      chk("next miss req",   32'(mem_req_valid), 32'd1);
      chk("next miss addr",  mem_req_addr, 32'h1010);

      // memory slow to accept: request held stable
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("slow req",  32'(mem_req_valid), 32'd1);
         chk("slow addr", mem_req_addr, 32'h1010);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;

      // redirect while waiting for fill of 0x1010
      branch_taken = 1'b1;
      branch_pc    = 32'h1008;
      tick();
      branch_taken = 1'b0;
      chk("wait no valid", 32'(fetch_instr_valid), 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_at(32'h1010);
      tick();
      mem_rsp_valid = 1'b0;
      chk("redir fill valid", 32'(fetch_instr_valid), 32'd0);
      tick();
      chk_out("redir", 32'h1008);

      // stall during hits
      stall_fetch = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall", 32'h1008);
      end
      stall_fetch = 1'b0;
      tick();
      chk_out("post stall", 32'h100C);
      tick();
      chk_out("installed", 32'h1010);
      chk("installed no req", 32'(mem_req_valid), 32'd0);
      tick();
      chk_out("installed+4", 32'h1014);

      // misaligned branch freezes fetch
      branch_taken = 1'b1;
      branch_pc    = 32'h2002;
      tick();
      branch_taken = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("exc set",   32'(fetch_exc_valid), 32'd1);
         chk("exc valid", 32'(fetch_instr_valid), 32'd0);
         chk("exc req",   32'(mem_req_valid), 32'd0);
         tick();
      end
      branch_taken = 1'b1;
      branch_pc    = 32'h1000;
      tick();
      branch_taken = 1'b0;
      chk("exc clear", 32'(fetch_exc_valid), 32'd0);
      chk("exc clear valid", 32'(fetch_instr_valid), 32'd0);
      tick();
      chk_out("after exc", 32'h1000);
      chk("after exc req", 32'(mem_req_valid), 32'd0);

      // reset while waiting for a fill
      branch_taken = 1'b1;
      branch_pc    = 32'h3000;
      tick();
      branch_taken = 1'b0;
      tick();
      chk("far req",  32'(mem_req_valid), 32'd1);
      chk("far addr", mem_req_addr, 32'h3000);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      reset_c       = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_at(32'h3000);
      #1;
      chk("rst2 req",   32'(mem_req_valid), 32'd0);
      chk("rst2 valid", 32'(fetch_instr_valid), 32'd0);
      chk("rst2 pc",    fetch_pc, 32'h1000);
      chk("rst2 addr",  mem_req_addr, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      reset_c       = 1'b1;
      tick();
      chk("boot req",  32'(mem_req_valid), 32'd1);
      chk("boot addr", mem_req_addr, 32'h1000);
      chk("boot valid", 32'(fetch_instr_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
